// File: rtl/router_pkg.sv
// Shared definitions for the router transmit path: phit width, phit type
// encodings, FSM state enumeration and the request length normaliser.
package router_pkg;

    localparam int PHIT_W = 18;

    localparam logic [1:0] PT_IDLE = 2'b00;
    localparam logic [1:0] PT_HEAD = 2'b01;
    localparam logic [1:0] PT_BODY = 2'b10;
    localparam logic [1:0] PT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    // A zero length still sends one body phit; oversize requests are clamped.
    function automatic logic [3:0] eff_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len == 4'd0)
            return 4'd1;
        if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Payload FIFO for router_tx: DEPTH entries, pointers carry one extra wrap bit
// so full and empty can be told apart without a separate occupancy counter.
module router_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             full;
    logic             push_en;
    logic             pop_en;

    assign empty      = (wr_ptr_reg == rd_ptr_reg);
    assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push_ready = !full;
    assign push_en    = push_valid && !full;
    assign pop_en     = pop && !empty;
    assign pop_data   = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/router_tx.sv
// Source-routed packet transmitter: head phit carries the route, body phits are
// drained from the payload FIFO. Define ROUTER_TX_STATS_EN to enable pkt_count.
module router_tx
    import router_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int MAX_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_route,
    input  logic [3:0]        req_len,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [15:0]       dat_word,
    output logic [PHIT_W-1:0] o,
    output logic              busy,
    output logic [15:0]       pkt_count
);
    state_t              state_reg;
    logic [15:0]         route_reg;
    logic [3:0]          remain_reg;
    logic [PHIT_W-1:0]   o_reg;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [15:0]         fifo_data;
    logic                last_phit;

    assign fifo_pop  = (state_reg == ST_BODY) && !fifo_empty;
    assign last_phit = (remain_reg == 4'd1);
    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign o         = o_reg;

    router_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (dat_valid),
        .push_ready (dat_ready),
        .push_data  (dat_word),
        .pop        (fifo_pop),
        .pop_data   (fifo_data),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            route_reg  <= '0;
            remain_reg <= '0;
            o_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    o_reg <= '0;
                    if (req_valid) begin
                        route_reg  <= req_route;
                        remain_reg <= eff_len(req_len, 4'(MAX_LEN));
                        state_reg  <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    o_reg     <= {PT_HEAD, route_reg};
                    state_reg <= ST_BODY;
                end
                ST_BODY: begin
                    // An empty FIFO stalls the packet indefinitely with idle phits.
                    if (!fifo_empty) begin
                        o_reg      <= {(last_phit ? PT_TAIL : PT_BODY), fifo_data};
                        remain_reg <= remain_reg - 4'd1;
                        if (last_phit)
                            state_reg <= ST_IDLE;
                    end else begin
                        o_reg <= '0;
                    end
                end
                default: begin
                    o_reg     <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ROUTER_TX_STATS_EN
    logic [15:0] pkt_count_reg;

    always_ff @(posedge clk) begin
        if (rst)
            pkt_count_reg <= '0;
        else if (fifo_pop && last_phit)
            pkt_count_reg <= pkt_count_reg + 16'd1;
    end

    assign pkt_count = pkt_count_reg;
`else
    assign pkt_count = '0;
`endif

endmodule
